keypad_entry_buffer: RTL and testbench

KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

---
 rtl/keypad_entry_buffer.sv | 139 +++++++++++++
 tb/tb_keypad_entry_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_buffer
// Description : Assembles BCD key presses into an entry register and queues
//               completed entries in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_buffer #(
    parameter int MAX_DIGITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        val,
    input  logic                              val_stb,
    input  logic                              rd_en,
    output logic [4*MAX_DIGITS-1:0]           entry,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
    output logic [4*MAX_DIGITS-1:0]           fifo_dout,
    output logic                              fifo_empty,
    output logic                              fifo_full,
    output logic                              overflow
);

    localparam int c_entry_w = 4 * MAX_DIGITS;
    localparam int c_cnt_w   = $clog2(MAX_DIGITS + 1);
    localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_occ_w   = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] c_key_bksp  = 4'hA;
    localparam logic [3:0] c_key_clear = 4'hE;
    localparam logic [3:0] c_key_enter = 4'hF;

    logic [c_entry_w-1:0] r_entry;
    logic [c_cnt_w-1:0]   r_digit_cnt;
    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_occ_w-1:0]   r_occ;
    logic                 r_overflow;

    logic [c_entry_w-1:0] w_entry_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_enter;
    logic                 w_can_accept;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty      = (r_occ == '0);
    assign w_full       = (r_occ == c_occ_w'(FIFO_DEPTH));
    assign w_pop        = rd_en && !w_empty;
    // A full FIFO still accepts when the consumer frees the head in the same cycle
    assign w_can_accept = !w_full || rd_en;
    assign w_enter      = val_stb && (val == c_key_enter) && (r_digit_cnt != '0);
    assign w_push       = w_enter && w_can_accept;

    always_comb begin
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_digit_cnt;
        if (val_stb) begin
            if (val <= 4'd9) begin
                if (r_digit_cnt < c_cnt_w'(MAX_DIGITS)) begin
                    w_entry_nxt = (r_entry << 4) | c_entry_w'(val);
                    w_cnt_nxt   = r_digit_cnt + 1'b1;
                end
            end else begin
                case (val)
                    c_key_bksp: begin
                        if (r_digit_cnt != '0) begin
                            w_entry_nxt = r_entry >> 4;
                            w_cnt_nxt   = r_digit_cnt - 1'b1;
                        end
                    end
                    c_key_clear: begin
                        w_entry_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                    c_key_enter: begin
                        if (w_push) begin
                            w_entry_nxt = '0;
                            w_cnt_nxt   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry     <= '0;
            r_digit_cnt <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_entry     <= w_entry_nxt;
            r_digit_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - 1'b1;
            end
            if (w_enter && !w_can_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= r_entry;
        end
    end

    assign entry      = r_entry;
    assign digit_cnt  = r_digit_cnt;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign fifo_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_buffer
// Description : Directed self-checking bench with an expected-entry queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_buffer;

    logic        clk;
    logic        reset;
    logic [3:0]  val;
    logic        val_stb;
    logic        rd_en;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb [$];

    keypad_entry_buffer #(.MAX_DIGITS(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .val        (val),
        .val_stb    (val_stb),
        .rd_en      (rd_en),
        .entry      (entry),
        .digit_cnt  (digit_cnt),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic key(input logic [3:0] v);
        val     = v;
        val_stb = 1'b1;
        @(negedge clk);
        val_stb = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] exp;
        chk({tag, "_nonempty"}, {31'd0, fifo_empty}, 32'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed empty expected entry", tag);
        end else begin
            exp = sb.pop_front();
            chk(tag, {16'd0, fifo_dout}, {16'd0, exp});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_entry"},  {16'd0, entry},      32'd0);
        chk({tag, "_cnt"},    {29'd0, digit_cnt},  32'd0);
        chk({tag, "_empty"},  {31'd0, fifo_empty}, 32'd1);
        chk({tag, "_full"},   {31'd0, fifo_full},  32'd0);
        chk({tag, "_dout"},   {16'd0, fifo_dout},  32'd0);
        chk({tag, "_ovf"},    {31'd0, overflow},   32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        val     = 4'h0;
        val_stb = 1'b0;
        rd_en   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_state("rst");

        // Back-to-back digit strobes, then enter
        val = 4'h1; val_stb = 1'b1;
        @(negedge clk); val = 4'h2;
        @(negedge clk); val = 4'h3;
        @(negedge clk); val_stb = 1'b0;
        chk("b2b_entry", {16'd0, entry}, 32'h0123);
        chk("b2b_cnt", {29'd0, digit_cnt}, 32'd3);
        sb.push_back(16'h0123);
        key(4'hF);
        chk("ent_empty", {31'd0, fifo_empty}, 32'd0);
        chk("ent_dout", {16'd0, fifo_dout}, {16'd0, sb[0]});
        chk("ent_entry", {16'd0, entry}, 32'd0);
        chk("ent_cnt", {29'd0, digit_cnt}, 32'd0);
        pop_chk("ent_pop");
        chk("ent_drained", {31'd0, fifo_empty}, 32'd1);
        chk("ent_dout0", {16'd0, fifo_dout}, 32'd0);

        // Digit limit and backspace
        key(4'h9); key(4'h8); key(4'h7); key(4'h6);
        chk("lim_entry", {16'd0, entry}, 32'h9876);
        chk("lim_cnt", {29'd0, digit_cnt}, 32'd4);
        key(4'h5);
        chk("lim_drop", {16'd0, entry}, 32'h9876);
        chk("lim_drop_cnt", {29'd0, digit_cnt}, 32'd4);
        key(4'hA);
        chk("bksp_entry", {16'd0, entry}, 32'h0987);
        chk("bksp_cnt", {29'd0, digit_cnt}, 32'd3);
        key(4'hB); key(4'hC); key(4'hD);
        chk("ign_entry", {16'd0, entry}, 32'h0987);
        key(4'hE);
        chk("clr_entry", {16'd0, entry}, 32'd0);
        chk("clr_cnt", {29'd0, digit_cnt}, 32'd0);
        key(4'hA);
        chk("bksp0_cnt", {29'd0, digit_cnt}, 32'd0);

        // Fill to full, overflow, drain in order
        for (int i = 1; i <= 5; i++) begin
            key(4'(i));
            if (i <= 4) sb.push_back(16'(i));
            key(4'hF);
            if (i == 4) chk("fill_full", {31'd0, fifo_full}, 32'd1);
            if (i == 3) chk("fill_notfull", {31'd0, fifo_full}, 32'd0);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_entry", {16'd0, entry}, 32'h0005);
        chk("ovf_cnt", {29'd0, digit_cnt}, 32'd1);
        for (int i = 0; i < 4; i++) pop_chk("drain");
        chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ovf_rst", {31'd0, overflow}, 32'd0);

        // Enter on a full FIFO with a same-cycle pop
        for (int i = 1; i <= 4; i++) begin
            key(4'h1); key(4'(i));
            sb.push_back(16'h0010 | 16'(i));
            key(4'hF);
        end
        chk("pp_full", {31'd0, fifo_full}, 32'd1);
        key(4'h1); key(4'h5);
        chk("pp_head", {16'd0, fifo_dout}, {16'd0, sb.pop_front()});
        sb.push_back(16'h0015);
        val = 4'hF; val_stb = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        val_stb = 1'b0; rd_en = 1'b0;
        chk("pp_full_after", {31'd0, fifo_full}, 32'd1);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        chk("pp_entry", {16'd0, entry}, 32'd0);
        for (int i = 0; i < 4; i++) pop_chk("pp_drain");
        chk("pp_empty", {31'd0, fifo_empty}, 32'd1);

        // Value without strobe, enter with no digits, pop on empty
        val = 4'h5;
        repeat (10) @(negedge clk);
        chk("nostb_entry", {16'd0, entry}, 32'd0);
        chk("nostb_cnt", {29'd0, digit_cnt}, 32'd0);
        key(4'hF);
        chk("ent0_empty", {31'd0, fifo_empty}, 32'd1);
        chk("ent0_entry", {16'd0, entry}, 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("uflow_empty", {31'd0, fifo_empty}, 32'd1);
        chk("uflow_full", {31'd0, fifo_full}, 32'd0);
        chk("uflow_dout", {16'd0, fifo_dout}, 32'd0);
        key(4'h7);
        sb.push_back(16'h0007);
        key(4'hF);
        pop_chk("uflow_pop");
        chk("uflow_empty2", {31'd0, fifo_empty}, 32'd1);

        // Push and pop together on an empty FIFO performs only the push
        key(4'h8);
        sb.push_back(16'h0008);
        val = 4'hF; val_stb = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        val_stb = 1'b0; rd_en = 1'b0;
        chk("pe_empty", {31'd0, fifo_empty}, 32'd0);
        pop_chk("pe_pop");

        // Reset mid-entry with stored data, colliding with strobe and pop
        key(4'h3); key(4'h1); sb.push_back(16'h0031); key(4'hF);
        key(4'h3); key(4'h2); sb.push_back(16'h0032); key(4'hF);
        key(4'h4); key(4'h2);
        chk("mid_entry", {16'd0, entry}, 32'h0042);
        chk("mid_dout", {16'd0, fifo_dout}, {16'd0, sb[0]});
        reset = 1'b1; val = 4'hF; val_stb = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        reset = 1'b0; val_stb = 1'b0; rd_en = 1'b0;
        sb.delete();
        chk_reset_state("mid_rst");
        key(4'h6);
        sb.push_back(16'h0006);
        key(4'hF);
        pop_chk("post_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
